// File: rtl/i2s_tx_pkg.sv
// Shared types and sizing helpers for the I2S transmit serializer.
package i2s_tx_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefSclkDiv   = 2;
  localparam int unsigned DefFifoDepth = 4;

  // Bits in one stereo frame (left word followed by right word).
  function automatic int unsigned frame_bits(input int unsigned data_width);
    return 2 * data_width;
  endfunction

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } tx_state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous FIFO holding packed {left, right} sample pairs.
module i2s_tx_fifo
  import i2s_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DefDataWidth,
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = cnt_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full   = (count_q == FullCnt);
  assign empty  = (count_q == '0);
  assign pop_ok = pop && !empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: buffers stereo pairs and shifts them out Philips-style
// (one-bit delay after WS changes), MSB first, with a divided bit clock.
module i2s_tx_serializer
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned SCLK_DIV   = DefSclkDiv,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  output logic                  sclk,
  output logic                  ws,
  output logic                  sd,
  output logic                  underrun,
  output logic                  busy
);

  localparam int unsigned FrameBits = frame_bits(DATA_WIDTH);
  localparam int unsigned BitCntW   = cnt_width(FrameBits);
  localparam int unsigned DivW      = cnt_width(SCLK_DIV);

  localparam logic [BitCntW-1:0] LastBit    = BitCntW'(FrameBits - 1);
  localparam logic [BitCntW-1:0] RightStart = BitCntW'(DATA_WIDTH);
  localparam logic [DivW-1:0]    DivLast    = DivW'(SCLK_DIV - 1);

  tx_state_e            state_q;
  logic [DivW-1:0]      div_q;
  logic [BitCntW-1:0]   bit_q;
  logic [FrameBits-1:0] shift_q;
  logic                 first_q;
  logic                 sclk_q;
  logic                 ws_q;
  logic                 sd_q;
  logic                 underrun_q;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FrameBits-1:0] fifo_rdata;

  logic tick;
  logic fall_evt;
  logic start;
  logic boundary;

  i2s_tx_fifo #(
    .WIDTH(FrameBits),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (sample_valid),
    .wdata({left_data, right_data}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    tick     = (div_q == DivLast);
    fall_evt = (state_q == StRun) && tick && sclk_q;
    start    = (state_q == StIdle) && enable && !fifo_empty;
    // The first n=0 event after IDLE only emits the idle zero; the pair is already loaded.
    boundary = fall_evt && (bit_q == '0) && !first_q;
    fifo_pop = start || (boundary && enable && !fifo_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      first_q    <= 1'b0;
      sclk_q     <= 1'b0;
      ws_q       <= 1'b1;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sclk_q <= 1'b0;
          ws_q   <= 1'b1;
          sd_q   <= 1'b0;
          div_q  <= '0;
          bit_q  <= '0;
          if (start) begin
            state_q <= StRun;
            shift_q <= fifo_rdata;
            first_q <= 1'b1;
          end
        end

        StRun: begin
          div_q <= tick ? '0 : div_q + DivW'(1);
          if (tick) begin
            sclk_q <= !sclk_q;
          end
          if (fall_evt) begin
            ws_q  <= (bit_q >= RightStart);
            bit_q <= (bit_q == LastBit) ? '0 : bit_q + BitCntW'(1);
            if (bit_q == '0) begin
              first_q <= 1'b0;
              if (first_q) begin
                sd_q <= 1'b0;
              end else begin
                // After 2*DATA_WIDTH-1 shifts the MSB holds the previous right LSB.
                sd_q <= shift_q[FrameBits-1];
                if (!enable) begin
                  state_q <= StDrain;
                end else if (!fifo_empty) begin
                  shift_q <= fifo_rdata;
                end else begin
                  shift_q    <= '0;
                  underrun_q <= 1'b1;
                end
              end
            end else begin
              sd_q    <= shift_q[FrameBits-1];
              shift_q <= shift_q << 1;
            end
          end
        end

        StDrain: begin
          div_q <= tick ? '0 : div_q + DivW'(1);
          if (tick) begin
            if (sclk_q) begin
              state_q <= StIdle;
              sclk_q  <= 1'b0;
              ws_q    <= 1'b1;
              sd_q    <= 1'b0;
            end else begin
              sclk_q <= 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign sample_ready = !fifo_full;
  assign sclk         = sclk_q;
  assign ws           = ws_q;
  assign sd           = sd_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a receiver process records SD/WS on every
// rising SCLK and each scenario compares the captured stream with hand-built frames.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] left_data = '0;
  logic [15:0] right_data = '0;
  logic        sclk;
  logic        ws;
  logic        sd;
  logic        underrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        cap_sd[$];
  logic        cap_ws[$];
  logic [31:0] pend[$];

  i2s_tx_serializer #(
    .DATA_WIDTH(16),
    .SCLK_DIV  (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .left_data   (left_data),
    .right_data  (right_data),
    .sclk        (sclk),
    .ws          (ws),
    .sd          (sd),
    .underrun    (underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    cap_sd.push_back(sd);
    cap_ws.push_back(ws);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Captured bits [off, off+len) packed MSB-first; missing bits read as x.
  function automatic logic [63:0] cap_bits(input int off, input int len, input bit use_ws);
    logic [63:0] v = '0;
    logic b;
    for (int k = 0; k < len; k++) begin
      if (off + k < cap_sd.size()) b = use_ws ? cap_ws[off + k] : cap_sd[off + k];
      else b = 1'bx;
      v = {v[62:0], b};
    end
    return v;
  endfunction

  task automatic push_pair(input logic [31:0] p);
    int t = 0;
    while (!sample_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    sample_valid = 1'b1;
    {left_data, right_data} = p;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Runs frames until busy drops; i counts negedges from the first busy cycle.
  task automatic run_frames(input int drop_at, input int force_at, input logic [31:0] force_pair,
                            output int busy_cyc, output int ur_cnt, output int ur_at);
    int t = 0;
    busy_cyc = 0;
    ur_cnt   = 0;
    ur_at    = -1;
    enable   = 1'b1;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("start_busy", busy, 1);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      busy_cyc++;
      if (underrun) begin
        ur_cnt++;
        ur_at = i;
      end
      if (force_at >= 0 && i == force_at + 1) check("ready_after_pushpop", sample_ready, 0);
      if (i == drop_at) enable = 1'b0;
      sample_valid = 1'b0;
      if (i == force_at) begin
        sample_valid = 1'b1;
        {left_data, right_data} = force_pair;
      end else if (pend.size() > 0 && sample_ready) begin
        sample_valid = 1'b1;
        {left_data, right_data} = pend.pop_front();
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    int bc, uc, ua, bad;
    logic [31:0] spairs [8];
    logic [31:0] fpairs [6];

    spairs = '{32'h8000_7FFF, 32'h0001_FFFE, 32'h1234_5678, 32'h9ABC_DEF0,
               32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0F0F_F0F0, 32'h5555_AAAA};
    fpairs = '{32'h0102_0304, 32'h1020_3040, 32'h7F00_00FF, 32'h8001_8001,
               32'h3C3C_C3C3, 32'h6996_9669};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_ws", ws, 1);
    check("rst_sd", sd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sample_ready, 1);
    rst = 1'b1;

    // Idle with enable low for 100 clk
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sclk !== 1'b0 || ws !== 1'b1 || sd !== 1'b0 || busy !== 1'b0 || sample_ready !== 1'b1)
        bad++;
    end
    check("idle_100", bad, 0);

    // Single frame then drain
    cap_sd.delete();
    cap_ws.delete();
    push_pair(32'hA5C3_0F01);
    run_frames(10, -1, '0, bc, uc, ua);
    check("single_busy_cycles", bc, 136);
    check("single_nbits", cap_sd.size(), 34);
    check("single_sd", cap_bits(0, 34, 1'b0), 64'h0000_0000_A5C3_0F01);
    check("single_ws", cap_bits(0, 34, 1'b1), 64'h0000_0002_0001_FFFE);
    check("single_underrun", uc, 0);
    check("single_idle_sclk", sclk, 0);
    check("single_idle_ws", ws, 1);
    check("single_idle_sd", sd, 0);

    // Back-to-back streaming of 8 pairs
    cap_sd.delete();
    cap_ws.delete();
    for (int k = 0; k < 4; k++) push_pair(spairs[k]);
    check("stream_ready_full", sample_ready, 0);
    for (int k = 4; k < 8; k++) pend.push_back(spairs[k]);
    run_frames(950, -1, '0, bc, uc, ua);
    check("stream_busy_cycles", bc, 1032);
    check("stream_nbits", cap_sd.size(), 258);
    for (int k = 0; k < 8; k++)
      check($sformatf("stream_pair%0d", k), cap_bits(2 + 32 * k, 32, 1'b0), {32'h0, spairs[k]});
    check("stream_underrun", uc, 0);
    check("stream_pend_left", pend.size(), 0);

    // Underrun after a single pair
    cap_sd.delete();
    cap_ws.delete();
    push_pair(32'h1234_ABCD);
    run_frames(200, -1, '0, bc, uc, ua);
    check("ur_count", uc, 1);
    check("ur_cycle", ua, 132);
    check("ur_busy_cycles", bc, 264);
    check("ur_nbits", cap_sd.size(), 66);
    check("ur_frame1", cap_bits(2, 32, 1'b0), 64'h0000_0000_1234_ABCD);
    check("ur_frame2", cap_bits(34, 32, 1'b0), 64'h0);

    // Push into a full FIFO on the boundary clk that pops
    cap_sd.delete();
    cap_ws.delete();
    for (int k = 0; k < 4; k++) push_pair(fpairs[k]);
    pend.push_back(fpairs[4]);
    run_frames(700, 131, fpairs[5], bc, uc, ua);
    check("full_busy_cycles", bc, 776);
    check("full_nbits", cap_sd.size(), 194);
    for (int k = 0; k < 6; k++)
      check($sformatf("full_pair%0d", k), cap_bits(2 + 32 * k, 32, 1'b0), {32'h0, fpairs[k]});
    check("full_underrun", uc, 0);

    // Reset at bit n=10 of the first frame, with a second pair still queued
    push_pair(32'hAAAA_5555);
    push_pair(32'h0F0F_0001);
    enable = 1'b1;
    bad = 0;
    while (!busy && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check("rstmid_start", busy, 1);
    repeat (46) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_sclk", sclk, 0);
    check("rstmid_ws", ws, 1);
    check("rstmid_sd", sd, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", sample_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_fifo_empty", busy, 0);
    enable = 1'b0;
    cap_sd.delete();
    cap_ws.delete();
    push_pair(32'hC001_8003);
    run_frames(10, -1, '0, bc, uc, ua);
    check("rstmid_busy_cycles", bc, 136);
    check("rstmid_nbits", cap_sd.size(), 34);
    check("rstmid_sd", cap_bits(0, 34, 1'b0), 64'h0000_0000_C001_8003);
    check("rstmid_underrun", uc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Synthesizable I2S transmitter master that turns stereo sample pairs into the serial I2S bus (SCLK, WS, SD). It is the stage directly upstream of the I2S interface. Its serial outputs drive the interface signals that the receiver-agent BFM samples. A 4-entry sample FIFO decouples the parallel producer from the serial frame timing.

## Interface
Parameters:
- DATA_WIDTH, 16: bits per channel word; legal 8..32.
- SCLK_DIV, 2: clk cycles per SCLK half-period; legal ≥1.
- FIFO_DEPTH, 4: stereo-pair entries; power of two.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 = run the bus, 0 = finish the current frame, then idle.
- sample_valid  input  1  producer has a pair on left_data/right_data.
- sample_ready  output  1  FIFO not full; a transfer occurs when valid && ready on a rising clk.
- left_data  input  DATA_WIDTH  left-channel word, two's complement.
- right_data  input  DATA_WIDTH  right-channel word.
- sclk  output  1  serial bit clock, registered.
- ws  output  1  word select; 0 = left, 1 = right.
- sd  output  1  serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame starts with the FIFO empty.
- busy  output  1  state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN. In IDLE, SCLK is held at 0.
- IDLE→RUN: enable=1 and FIFO non-empty. On entry, pop one pair into a 2*DATA_WIDTH shift register {left,right}. Clear the divider and the bit counter.
- RUN:
  - The divider counts 0..SCLK_DIV-1. At the terminal count, sclk toggles.
  - Updates happen only on a falling-edge event, i.e. the clk where sclk goes 1→0.
  - A bit counter n runs 0..2*DATA_WIDTH-1 and increments on each falling event.
  - ws = 0 for n < DATA_WIDTH and 1 otherwise.
  - Philips one-bit delay: at falling event n, sd = frame bit n-1 (bit 0 = left MSB). At n=0, sd = previous frame's right LSB, or 0 for the first frame after IDLE.
- Frame boundary, at the falling event that wraps n from 2*DATA_WIDTH-1 to 0:
  - enable=1 and FIFO non-empty: pop the next pair.
  - enable=1 and FIFO empty: load all-zeros and pulse underrun.
  - enable=0: go to DRAIN.
- DRAIN: emit the n=0 event (ws=0, sd=right LSB of the last frame). Then, at the next rising-edge event, go to IDLE with sclk=0, ws=1, sd=0.
- The FIFO accepts writes in every state. A simultaneous push and pop on a full FIFO is legal: the count is unchanged, and ready stays 0 that cycle.
- enable toggling mid-frame has no effect until the frame boundary.

## Timing
- Reset values: sclk=0, ws=1, sd=0, underrun=0, busy=0, FIFO empty, sample_ready=1.
- Reset may assert at any time. It clears the FSM, the divider, the bit counter, the shift register and the FIFO immediately. Any partially sent frame is discarded.
- SCLK period is 2*SCLK_DIV clk. A frame is 2*DATA_WIDTH SCLK periods.
- First falling event: 2*SCLK_DIV clk after leaving IDLE. The first rising toggle occurs SCLK_DIV clk after leaving IDLE.
- All outputs are registered. ws and sd change only in the same clk as the sclk 1→0 transition.
- sample_ready is the combinational !full of the registered count.
- underrun is high for exactly one clk, coincident with the n=0 falling event.
- The pop occurs in the clk of the boundary falling event. A sample pushed in that same clk is seen only if the FIFO was already non-empty.

## Structure
- Package i2s_tx_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - localparam helpers FRAME_BITS = 2*DATA_WIDTH and the counter widths via $clog2;
  - the default parameter constants.
- Sub-module i2s_tx_fifo: synchronous FIFO, width 2*DATA_WIDTH, depth FIFO_DEPTH. It has push/pop/full/empty and an asynchronous active-low reset on rst.
- The top-level module holds the divider, the FSM, the bit counter and the output registers.

## Test plan
- Reset, then idle: hold enable=0 and push nothing for 100 clk. Required: sclk=0, ws=1, sd=0, busy=0, sample_ready=1 throughout.
- Single frame (DATA_WIDTH=16, SCLK_DIV=2): push left=16'hA5C3, right=16'h0F01, enable=1, drop enable after 10 clk. Required:
  - one frame of 128 clk, then the DRAIN edge, then IDLE;
  - sampled on rising sclk, sd shows 0, A5C3 MSB-first, 0F01, then the LSB 1 on the drain edge;
  - ws falls one SCLK before the left MSB.
- Back-to-back streaming: push 8 pairs with valid held high, enable=1. Required:
  - ready drops after 4 entries are buffered;
  - 8 contiguous frames, no gaps, no underrun;
  - the receiver BFM captures all 8 pairs in order.
- Underrun: enable=1 with 1 pair pushed. Required: frame 1 carries the data; at the next boundary, underrun pulses once; frame 2 is all zeros while SCLK keeps running.
- Full FIFO with simultaneous push and pop: keep 4 entries and push at the boundary clk. Required: count stays 4, no entry is lost or duplicated.
- Reset mid-frame: assert rst at bit n=10 of frame 1. Required: outputs return to reset values immediately, FIFO is empty, and the next enable starts a clean frame with sd=0 at n=0.
